q299_inv_unit: RTL and testbench



---
 rtl/q299_inv_unit.sv | 125 ++++++++++++
 tb/tb_q299_inv_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/q299_inv_unit.sv
// Purpose: 3-share threshold inverse of the Q299 quadratic map over all 16 nibbles of a 64-bit state, 4 nibbles per beat.
// Latency: out_valid rises 4 cycles after the accept edge; one state per 5 cycles with out_ready held high.
// Backpressure: results are held stable in DONE until out_ready; in_ready follows out_ready there so a new state can overlap the handoff.
module q299_inv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_sh0,
  input  logic [63:0] in_sh1,
  input  logic [63:0] in_sh2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_sh0,
  output logic [63:0] out_sh1,
  output logic [63:0] out_sh2
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [2:0][63:0]  ish_q, ish_d;   // input shift register, share index outermost
  logic [2:0][63:0]  osh_q, osh_d;   // output shift register (the single TI register stage)
  logic [2:0][15:0]  comp_out;       // component outputs for the current beat
  logic              accept;

  // Cross-share quadratic term for share i: u_i v_i ^ u_i v_(i+1) ^ u_(i+1) v_i.
  function automatic logic p_term(input logic ui, input logic vi,
                                  input logic ui1, input logic vi1);
    return (ui & vi) ^ (ui & vi1) ^ (ui1 & vi);
  endfunction

  // One component function: a is share i of the nibble, b is share i+1.
  // Only a contributes linear terms, and no third share is visible here.
  function automatic logic [3:0] inv_comp(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] x;
    x[3] = a[3];
    x[2] = a[2] ^ p_term(a[3], a[2], b[3], b[2]) ^ p_term(a[3], a[0], b[3], b[0]);
    x[1] = a[1] ^ p_term(a[3], a[1], b[3], b[1]) ^ p_term(a[3], a[2], b[3], b[2]);
    x[0] = a[0] ^ p_term(a[3], a[1], b[3], b[1]);
    return x;
  endfunction

  // 12 component instances: 3 output shares x 4 nibbles of the low 16 bits.
  for (genvar gi = 0; gi < 3; gi++) begin : g_share
    for (genvar gj = 0; gj < 4; gj++) begin : g_nib
      assign comp_out[gi][4*gj +: 4] = inv_comp(ish_q[gi][4*gj +: 4],
                                                ish_q[(gi + 1) % 3][4*gj +: 4]);
    end
  end

  // Next-state, handshake outputs and shift-register updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ish_d     = ish_q;
    osh_d     = osh_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        for (int i = 0; i < 3; i++) begin
          ish_d[i] = {16'h0000, ish_q[i][63:16]};
          osh_d[i] = {comp_out[i], osh_q[i][63:16]};
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            accept  = 1'b1;
            state_d = S_BUSY;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (accept) begin
      ish_d = {in_sh2, in_sh1, in_sh0};
      cnt_d = 2'd0;
    end
  end

  // State, counter and share registers; reset discards any partial state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      ish_q   <= '0;
      osh_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ish_q   <= ish_d;
      osh_q   <= osh_d;
    end
  end

  assign out_sh0 = osh_q[0];
  assign out_sh1 = osh_q[1];
  assign out_sh2 = osh_q[2];

endmodule

// File: tb/tb_q299_inv_unit.sv
// Purpose: directed bench for q299_inv_unit (reset, nibble map, non-completeness, back-to-back, backpressure, reset abort).
// Latency: expects out_valid 4 cycles after the accept edge.
// Backpressure: drives out_ready low in DONE and holds in_valid high to probe for spurious accepts.
module tb_q299_inv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_sh0, in_sh1, in_sh2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sh0, out_sh1, out_sh2;

  int errors = 0;
  int checks = 0;

  q299_inv_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sh0    (in_sh0),
    .in_sh1    (in_sh1),
    .in_sh2    (in_sh2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sh0   (out_sh0),
    .out_sh1   (out_sh1),
    .out_sh2   (out_sh2)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference shared component output for share i from shares a (=i) and b (=i+1).
  function automatic logic [63:0] mdl(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    logic [3:0]  u, v;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      u = a[4*k +: 4];
      v = b[4*k +: 4];
      r[4*k+3] = u[3];
      r[4*k+2] = u[2] ^ (u[3]&u[2]) ^ (u[3]&v[2]) ^ (v[3]&u[2])
                      ^ (u[3]&u[0]) ^ (u[3]&v[0]) ^ (v[3]&u[0]);
      r[4*k+1] = u[1] ^ (u[3]&u[1]) ^ (u[3]&v[1]) ^ (v[3]&u[1])
                      ^ (u[3]&u[2]) ^ (u[3]&v[2]) ^ (v[3]&u[2]);
      r[4*k]   = u[0] ^ (u[3]&u[1]) ^ (u[3]&v[1]) ^ (v[3]&u[1]);
    end
    return r;
  endfunction

  // Present a state and return once it has been accepted (ok=0 on timeout).
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                      output bit ok);
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_sh0 = a; in_sh1 = b; in_sh2 = c;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  // Wait for out_valid; lat counts edges after the accept edge (-1 on timeout).
  task automatic collect(output logic [63:0] o0, output logic [63:0] o1,
                         output logic [63:0] o2, output int lat);
    lat = -1; o0 = '0; o1 = '0; o2 = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        o0 = out_sh0; o1 = out_sh1; o2 = out_sh2;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_sh0 = '0; in_sh1 = '0; in_sh2 = '0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++;
    if ({out_sh0, out_sh1, out_sh2} !== 192'd0)
      begin errors++; $display("FAIL reset_out_sh got=%h %h %h want=0", out_sh0, out_sh1, out_sh2); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_release_out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_constant();
    bit ok; int lat; logic [63:0] o0, o1, o2;
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, ok);
    collect(o0, o1, o2, lat);
    checks++;
    if (!ok || lat != 4) begin errors++; $display("FAIL const_latency got=%0d ok=%0d want=4", lat, ok); end
    checks++;
    if ((o0 ^ o1 ^ o2) !== 64'hEEEE_EEEE_EEEE_EEEE)
      begin errors++; $display("FAIL const_xor got=%h want=eeeeeeeeeeeeeeee", o0 ^ o1 ^ o2); end
    checks++;
    if (o0 !== 64'hEEEE_EEEE_EEEE_EEEE) begin errors++; $display("FAIL const_sh0 got=%h want=eeeeeeeeeeeeeeee", o0); end
    checks++;
    if ((o1 | o2) !== 64'h0) begin errors++; $display("FAIL const_sh12 got=%h %h want=0", o1, o2); end
  endtask

  task automatic test_nibble_map();
    bit ok; int lat; logic [63:0] o0, o1, o2, m1, m2;
    logic [63:0] y;
    y = 64'h0123_4567_89AB_CDEF;
    for (int n = 0; n < 100; n++) begin
      m1 = rnd64(); m2 = rnd64();
      send(y ^ m1 ^ m2, m1, m2, ok);
      collect(o0, o1, o2, lat);
      if (n == 0) begin
        checks++;
        if (!ok || lat != 4) begin errors++; $display("FAIL map_latency got=%0d ok=%0d want=4", lat, ok); end
      end
      checks++;
      if ((o0 ^ o1 ^ o2) !== 64'h0123_4567_8D9C_AFBE)
        begin errors++; $display("FAIL map_xor iter=%0d got=%h want=012345678d9cafbe", n, o0 ^ o1 ^ o2); end
    end
  endtask

  task automatic test_noncomplete();
    bit ok; int lat; logic [63:0] o0, o1, o2, s0, s1, s2, d, y;
    logic [63:0] e0, e1, e2;
    y  = 64'h3C5A_96F0_0F69_A5C3;
    s1 = rnd64(); s2 = rnd64(); s0 = y ^ s1 ^ s2;
    e0 = mdl(s0, s1); e1 = mdl(s1, s2); e2 = mdl(s2, s0);
    send(s0, s1, s2, ok);
    collect(o0, o1, o2, lat);
    checks++;
    if (o0 !== e0 || o1 !== e1 || o2 !== e2)
      begin errors++; $display("FAIL nc_base got=%h %h %h want=%h %h %h", o0, o1, o2, e0, e1, e2); end
    for (int k = 0; k < 3; k++) begin
      d = rnd64() | 64'h8888_8888_8888_8888;
      case (k)
        0: send(s0, s1, s2 ^ d, ok);
        1: send(s0 ^ d, s1, s2, ok);
        default: send(s0, s1 ^ d, s2, ok);
      endcase
      collect(o0, o1, o2, lat);
      checks++;
      if (!ok || lat != 4) begin errors++; $display("FAIL nc_latency pair=%0d got=%0d want=4", k, lat); end
      checks++;
      case (k)
        0: if (o0 !== e0) begin errors++; $display("FAIL nc_sh0 got=%h want=%h", o0, e0); end
        1: if (o1 !== e1) begin errors++; $display("FAIL nc_sh1 got=%h want=%h", o1, e1); end
        default: if (o2 !== e2) begin errors++; $display("FAIL nc_sh2 got=%h want=%h", o2, e2); end
      endcase
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] pat; logic [63:0] xa, xb, m1, m2; logic ir4;
    pat = '0; xa = '0; xb = '0; ir4 = 1'b0;
    m1 = rnd64(); m2 = rnd64();
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_sh0 = 64'hFEDC_BA98_7654_3210 ^ m1 ^ m2; in_sh1 = m1; in_sh2 = m2;
    @(posedge clk);
    #1;
    m1 = rnd64(); m2 = rnd64();
    in_sh0 = 64'h0123_4567_89AB_CDEF ^ m1 ^ m2; in_sh1 = m1; in_sh2 = m2;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      pat[c] = out_valid;
      if (c == 4) begin xa = out_sh0 ^ out_sh1 ^ out_sh2; ir4 = in_ready; end
      if (c == 5) in_valid = 1'b0;
      if (c == 9) xb = out_sh0 ^ out_sh1 ^ out_sh2;
    end
    checks++;
    if (pat !== 11'h210) begin errors++; $display("FAIL b2b_pattern got=%b want=01000010000", pat); end
    checks++;
    if (ir4 !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got=%b want=1", ir4); end
    checks++;
    if (xa !== 64'hEBFA_C9D8_7654_3210) begin errors++; $display("FAIL b2b_first got=%h want=ebfac9d876543210", xa); end
    checks++;
    if (xb !== 64'h0123_4567_8D9C_AFBE) begin errors++; $display("FAIL b2b_second got=%h want=012345678d9cafbe", xb); end
  endtask

  task automatic test_backpressure();
    bit ok; int lat; logic [63:0] o0, o1, o2, m1, m2; bit stable;
    m1 = rnd64(); m2 = rnd64();
    out_ready = 1'b0;
    send(64'h9999_9999_9999_9999 ^ m1 ^ m2, m1, m2, ok);
    collect(o0, o1, o2, lat);
    checks++;
    if (!ok || lat != 4) begin errors++; $display("FAIL bp_latency got=%0d want=4", lat); end
    checks++;
    if ((o0 ^ o1 ^ o2) !== 64'hDDDD_DDDD_DDDD_DDDD)
      begin errors++; $display("FAIL bp_xor got=%h want=dddddddddddddddd", o0 ^ o1 ^ o2); end
    in_valid = 1'b1;
    in_sh0 = rnd64(); in_sh1 = rnd64(); in_sh2 = rnd64();
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          out_sh0 !== o0 || out_sh1 !== o1 || out_sh2 !== o2) stable = 1'b0;
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL bp_hold got=unstable want=stable"); end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL bp_release got=ov%b ir%b want=ov0 ir1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid();
    bit ok; int lat; logic [63:0] o0, o1, o2, m1, m2; bit quiet;
    m1 = rnd64(); m2 = rnd64();
    send(64'h0123_4567_89AB_CDEF ^ m1 ^ m2, m1, m2, ok);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL rst_mid_flags got=ov%b ir%b want=ov0 ir1", out_valid, in_ready); end
    checks++;
    if ({out_sh0, out_sh1, out_sh2} !== 192'd0)
      begin errors++; $display("FAIL rst_mid_out got=%h %h %h want=0", out_sh0, out_sh1, out_sh2); end
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL rst_mid_quiet got=activity want=idle"); end
    m1 = rnd64(); m2 = rnd64();
    send(64'h8888_8888_8888_8888 ^ m1 ^ m2, m1, m2, ok);
    collect(o0, o1, o2, lat);
    checks++;
    if (!ok || lat != 4) begin errors++; $display("FAIL rst_mid_latency got=%0d want=4", lat); end
    checks++;
    if ((o0 ^ o1 ^ o2) !== 64'h8888_8888_8888_8888)
      begin errors++; $display("FAIL rst_mid_xor got=%h want=8888888888888888", o0 ^ o1 ^ o2); end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_nibble_map();
    test_noncomplete();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
